// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter feeding one four-phase req/ack CDC channel from the slow domain.
// Optional watchdog on the REQ/RELEASE phases is enabled with `define CDC_ARB_TIMEOUT_EN.
module cdc_handshake_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_slow,
    input  logic                          rst_slow,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          xfer_req,
    output logic [DATA_WIDTH-1:0]         xfer_data,
    input  logic                          ack_sync,
    output logic                          xfer_done,
    output logic [$clog2(NUM_REQ)-1:0]    xfer_id,
    output logic                          timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic                    xfer_req_r, xfer_req_nxt_s;
    logic [DATA_WIDTH-1:0]   xfer_data_r, xfer_data_nxt_s;
    logic [IDX_W-1:0]        xfer_id_r, xfer_id_nxt_s;
    logic                    xfer_done_r, xfer_done_nxt_s;
    logic                    timeout_r, timeout_nxt_s;
    logic                    timeout_hit_s;

    logic [NUM_REQ-1:0]      grant_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic                    grant_found_s;

    // Round-robin search starting at rr_ptr_r, wrapping modulo NUM_REQ
    always_comb begin
        int  idx_v;
        logic hit_v;
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v         = int'(rr_ptr_r) + k;
            idx_v         = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
            hit_v         = !grant_found_s && req_valid[idx_v[IDX_W-1:0]];
            grant_idx_s   = hit_v ? idx_v[IDX_W-1:0] : grant_idx_s;
            grant_found_s = grant_found_s | hit_v;
        end
        grant_s[grant_idx_s] = grant_found_s;
    end

    assign req_ready = grant_s & {NUM_REQ{state_r == ST_IDLE}};

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wdog_cnt_r;

    // Watchdog counter: cleared on any state change, counts while a handshake is open
    always_ff @(posedge clk_slow) begin
        if (rst_slow) begin
            wdog_cnt_r <= '0;
        end else if (state_nxt_s != state_r) begin
            wdog_cnt_r <= '0;
        end else if (state_r != ST_IDLE) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end else begin
            wdog_cnt_r <= '0;
        end
    end

    assign timeout_hit_s = (state_r != ST_IDLE) && (wdog_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output logic for the handshake FSM
    always_comb begin
        state_nxt_s     = state_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        xfer_req_nxt_s  = xfer_req_r;
        xfer_data_nxt_s = xfer_data_r;
        xfer_id_nxt_s   = xfer_id_r;
        xfer_done_nxt_s = 1'b0;
        timeout_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    xfer_data_nxt_s = req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    xfer_id_nxt_s   = grant_idx_s;
                    rr_ptr_nxt_s    = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ?
                                      '0 : (grant_idx_s + IDX_W'(1));
                    xfer_req_nxt_s  = 1'b1;
                    state_nxt_s     = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    xfer_req_nxt_s = 1'b0;
                    state_nxt_s    = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    xfer_req_nxt_s = 1'b0;
                    timeout_nxt_s  = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    xfer_req_nxt_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    xfer_done_nxt_s = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else if (timeout_hit_s) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    xfer_req_nxt_s = 1'b0;
                end
            end
            default: begin
                xfer_req_nxt_s = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk_slow) begin
        if (rst_slow) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            xfer_req_r  <= 1'b0;
            xfer_data_r <= '0;
            xfer_id_r   <= '0;
            xfer_done_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            xfer_req_r  <= xfer_req_nxt_s;
            xfer_data_r <= xfer_data_nxt_s;
            xfer_id_r   <= xfer_id_nxt_s;
            xfer_done_r <= xfer_done_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign xfer_req    = xfer_req_r;
    assign xfer_data   = xfer_data_r;
    assign xfer_id     = xfer_id_r;
    assign xfer_done   = xfer_done_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Directed bench for cdc_handshake_arbiter: arbitration order, handshake timing, reset and watchdog.
module tb_cdc_handshake_arbiter;

    logic        clk_slow = 1'b0;
    logic        rst_slow;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        xfer_req;
    logic [7:0]  xfer_data;
    logic        ack_sync;
    logic        xfer_done;
    logic [1:0]  xfer_id;
    logic        timeout_err;

    int err_cnt = 0;
    int chk_cnt = 0;

    cdc_handshake_arbiter #(
        .NUM_REQ       (4),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_slow   (clk_slow),
        .rst_slow   (rst_slow),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .ack_sync   (ack_sync),
        .xfer_done  (xfer_done),
        .xfer_id    (xfer_id),
        .timeout_err(timeout_err)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    // Full minimum-length transfer: grant, ack high next edge, ack low the edge after
    task automatic do_xfer(input int id, input logic [7:0] d, input string tag);
        #1;
        check_eq({tag, ".ready"}, 32'(req_ready), 32'(1) << id);
        tick();
        check_eq({tag, ".req"}, 32'(xfer_req), 32'd1);
        check_eq({tag, ".id"}, 32'(xfer_id), 32'(id));
        check_eq({tag, ".data"}, 32'(xfer_data), 32'(d));
        check_eq({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        ack_sync = 1'b1;
        tick();
        check_eq({tag, ".req_fall"}, 32'(xfer_req), 32'd0);
        ack_sync = 1'b0;
        tick();
        check_eq({tag, ".done"}, 32'(xfer_done), 32'd1);
    endtask

    initial begin
        int bad;
        int done_seen;

        rst_slow  = 1'b1;
        ack_sync  = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h4433_2211;
        tick();
        tick();
        check_eq("rst.req", 32'(xfer_req), 32'd0);
        check_eq("rst.data", 32'(xfer_data), 32'd0);
        check_eq("rst.id", 32'(xfer_id), 32'd0);
        check_eq("rst.done", 32'(xfer_done), 32'd0);
        check_eq("rst.tout", 32'(timeout_err), 32'd0);
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        rst_slow = 1'b0;

        // Round-robin with everyone requesting
        req_valid = 4'b1111;
        do_xfer(0, 8'h11, "rr0");
        do_xfer(1, 8'h22, "rr1");
        do_xfer(2, 8'h33, "rr2");
        do_xfer(3, 8'h44, "rr3");
        do_xfer(0, 8'h11, "rr0b");

        // Single transfer with a slow far side: ack 3 cycles after req, drop 2 after fall
        req_valid        = 4'b0100;
        req_data[23:16]  = 8'hA5;
        #1;
        check_eq("one.ready", 32'(req_ready), 32'b0100);
        done_seen = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) req_valid = 4'b0000;
            check_eq("one.req", 32'(xfer_req), 32'(e < 3));
            check_eq("one.done", 32'(xfer_done), 32'(e == 5));
            check_eq("one.data", 32'(xfer_data), 32'hA5);
            check_eq("one.id", 32'(xfer_id), 32'd2);
            done_seen += int'(xfer_done);
            if (e == 2) ack_sync = 1'b1;
            else if (e == 4) ack_sync = 1'b0;
        end
        check_eq("one.done_count", 32'(done_seen), 32'd1);

        // Requester 1 withdraws while 3 keeps asking
        req_valid = 4'b0001;
        #1;
        check_eq("wd.ready0", 32'(req_ready), 32'b0001);
        tick();
        check_eq("wd.id0", 32'(xfer_id), 32'd0);
        req_valid       = 4'b1010;
        req_data[15:8]  = 8'hBB;
        req_data[31:24] = 8'h3C;
        #1;
        check_eq("wd.ready_busy", 32'(req_ready), 32'd0);
        ack_sync = 1'b1;
        tick();
        req_valid = 4'b1000;
        ack_sync  = 1'b0;
        tick();
        check_eq("wd.done", 32'(xfer_done), 32'd1);
        #1;
        check_eq("wd.ready3", 32'(req_ready), 32'b1000);
        tick();
        check_eq("wd.id3", 32'(xfer_id), 32'd3);
        check_eq("wd.data3", 32'(xfer_data), 32'h3C);
        check_eq("wd.req3", 32'(xfer_req), 32'd1);
        req_valid = 4'b0000;
        ack_sync  = 1'b1;
        tick();
        ack_sync = 1'b0;
        tick();
        check_eq("wd.done3", 32'(xfer_done), 32'd1);

        // Reset in the middle of REQ
        req_valid = 4'b0100;
        tick();
        check_eq("mr.req", 32'(xfer_req), 32'd1);
        req_valid = 4'b0000;
        tick();
        rst_slow = 1'b1;
        tick();
        rst_slow = 1'b0;
        check_eq("mr.req_low", 32'(xfer_req), 32'd0);
        check_eq("mr.done", 32'(xfer_done), 32'd0);
        check_eq("mr.id", 32'(xfer_id), 32'd0);
        check_eq("mr.data", 32'(xfer_data), 32'd0);
        req_valid = 4'b1111;
        #1;
        check_eq("mr.ptr", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();
        check_eq("mr.done2", 32'(xfer_done), 32'd0);

        // Ack left high from before capture completes REQ on the next sample
        ack_sync  = 1'b1;
        req_valid = 4'b0010;
        #1;
        check_eq("sp.ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        check_eq("sp.req", 32'(xfer_req), 32'd1);
        check_eq("sp.data", 32'(xfer_data), 32'hBB);
        tick();
        check_eq("sp.req_fall", 32'(xfer_req), 32'd0);
        ack_sync = 1'b0;
        tick();
        check_eq("sp.done", 32'(xfer_done), 32'd1);

        // Far side never answers
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check_eq("to.req", 32'(xfer_req), 32'd1);
        check_eq("to.id", 32'(xfer_id), 32'd0);
        bad = 0;
`ifdef CDC_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            if (xfer_req !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        check_eq("to.hold", 32'(bad), 32'd0);
        tick();
        check_eq("to.pulse", 32'(timeout_err), 32'd1);
        check_eq("to.req_fall", 32'(xfer_req), 32'd0);
        tick();
        check_eq("to.pulse_end", 32'(timeout_err), 32'd0);
        check_eq("to.no_done", 32'(xfer_done), 32'd0);
`else
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (xfer_req !== 1'b1 || timeout_err !== 1'b0 || xfer_done !== 1'b0) bad++;
        end
        check_eq("to.wait", 32'(bad), 32'd0);
        check_eq("to.ready_busy", 32'(req_ready), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_arbiter.md
# cdc_handshake_arbiter

Source-domain controller that shares one four-phase req/ack clock-domain-crossing channel among several requesters. It arbitrates round-robin between requesters, captures the winning word, and holds it stable on a single bundled data bus. It then drives the request level toward the far-domain synchronizer and sequences the full four-phase handshake against the already-synchronized acknowledge. It sits in the slow domain, directly in front of the bit synchronizers that carry `xfer_req` out and `ack_sync` back.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: payload width per requester.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in REQ/RELEASE. Used only with `CDC_ARB_TIMEOUT_EN`.

- `clk_slow` in 1: the single clock; all state updates on its rising edge.
- `rst_slow` in 1: reset, synchronous and active-high.
- `req_valid` in NUM_REQ: per-requester valid. Held until its ready is seen.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `xfer_req` out 1: registered request level to the far-domain synchronizer.
- `xfer_data` out DATA_WIDTH: registered bundled payload. Stable from capture until `xfer_done`.
- `ack_sync` in 1: far-domain acknowledge, already synchronized into `clk_slow`.
- `xfer_done` out 1: one-cycle completion pulse.
- `xfer_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `timeout_err` out 1: one-cycle watchdog pulse. Tied 0 without `CDC_ARB_TIMEOUT_EN`.

## Operation
- States: IDLE, REQ, RELEASE.
- **IDLE**
  - `req_ready` = grant & {NUM_REQ{state==IDLE}}, combinational. Grant is round-robin over `req_valid`.
  - Search starts at `rr_ptr` and wraps modulo NUM_REQ.
  - On a cycle with any valid:
    - the granted word is registered into `xfer_data`;
    - `xfer_id` <= granted index;
    - `rr_ptr` <= (index+1) mod NUM_REQ;
    - `xfer_req` <= 1;
    - next state REQ.
- **REQ:** hold `xfer_req`=1. When `ack_sync`=1 is sampled: `xfer_req` <= 0, next state RELEASE.
- **RELEASE:** hold `xfer_req`=0. When `ack_sync`=0 is sampled: `xfer_done` <= 1, next state IDLE.
- `ack_sync` is ignored in IDLE.
  - If it is still high on entry to IDLE (spurious), a capture proceeds normally. REQ then completes on the next sampled 1.
- Requesters never see back-pressure other than `req_ready`=0. A deasserted `req_valid` simply drops out of arbitration; no protocol error.
- Reset mid-handshake: all state returns to reset values. The in-flight word is lost and no `xfer_done` is issued. The far side must tolerate `xfer_req` falling early.
- Reset values:
  - state IDLE;
  - `xfer_req`=0, `xfer_data`=0, `xfer_id`=0;
  - `xfer_done`=0, `timeout_err`=0;
  - `rr_ptr`=0, so requester 0 has highest priority after reset.

## Timing
- Capture edge T: `req_ready[g]`=1 in the cycle before T. `xfer_req`=1 and `xfer_data` valid from T.
- `ack_sync` first sampled high at edge A: `xfer_req`=0 from A.
- `ack_sync` first sampled low at edge B: `xfer_done`=1 for the cycle after B.
- New grant is possible in the same cycle `xfer_done` is high, so `xfer_done` and `req_ready` may coincide.
- Minimum transfer: 3 cycles (capture, one REQ cycle, one RELEASE cycle).
- Throughput is bounded by the far-side round trip.

## Configuration
- `CDC_ARB_TIMEOUT_EN` defined:
  - A counter clears on every state change and increments in REQ and RELEASE.
  - Reaching TIMEOUT_CYCLES causes `timeout_err` to pulse 1 cycle, `xfer_req` <= 0, and forced return to IDLE without `xfer_done`.
- `CDC_ARB_TIMEOUT_EN` undefined: no counter, `timeout_err` constant 0, and the FSM waits indefinitely.

## Test plan
- **Reset values:** Reset, then all `req_valid`=4'b1111 -> `req_ready`=4'b0001 first. Following grants go 1, 2, 3, 0, each only after the prior `xfer_done`.
- **Single transfer:** Requester 2 sends 8'hA5; far model acks 3 cycles after `xfer_req` and drops 2 cycles after it falls. `xfer_data`=8'hA5 and `xfer_id`=2 stay stable throughout; `xfer_done` pulses exactly once; total cycles match the Timing rules.
- **Valid withdrawn:** Requester 1 valid withdrawn while requester 3 holds -> requester 3 granted next with no stall. Data of the withdrawn requester is never captured.
- **Reset mid-handshake:** `rst_slow` pulsed during REQ -> next cycle `xfer_req`=0, state IDLE, no `xfer_done`, `rr_ptr`=0.
- **Timeout:** With `CDC_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `ack_sync` is held 0 -> `timeout_err` pulses 16 cycles after entering REQ and `xfer_req` falls. Without the macro, the FSM stays in REQ for 1000 cycles.
